// File: rtl/coef_stream_loader_if.sv
// Input beat stream from the DMA read FIFO into the coefficient loader.
// The master drives valid/data and the slave returns ready.
interface coef_stream_loader_if #(
    parameter int LANES = 2
);
    logic                Rm_tvalid;
    logic [32*LANES-1:0] Rm_tdata;
    logic                Rm_tready;

    modport master (
        output Rm_tvalid,
        output Rm_tdata,
        input  Rm_tready
    );

    modport slave (
        input  Rm_tvalid,
        input  Rm_tdata,
        output Rm_tready
    );
endinterface

// File: rtl/coef_stream_loader.sv
// Stream-to-coefficient-RAM loader: reduces LANES words per beat into [0,Q) and writes them.
// Optional sticky range checking is built when COEF_RANGE_CHECK_EN is defined.
module coef_stream_loader #(
    parameter int LANES  = 2,
    parameter int DEPTH  = 256,
    parameter int COEF_W = 23,
    parameter int Q      = 8380417,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_module_start,
    input  logic                     i_read_working,
    input  logic [1:0]               i_mode,
    coef_stream_loader_if.slave      s_rm,
    output logic [LANES-1:0]         o_coef_we,
    output logic [ADDR_W*LANES-1:0]  o_coef_addr,
    output logic [COEF_W*LANES-1:0]  o_coef_din,
    output logic                     o_busy,
    output logic                     o_module_done,
    output logic                     o_range_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(DEPTH - LANES);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(LANES);
    localparam logic [32:0]       Q33       = 33'(Q);

    state_t                     r_state;
    logic                       r_drain;
    logic [ADDR_W-1:0]          r_base;
    logic                       r_busy;
    logic                       r_done;

    logic                       r_s1_vld;
    logic [32*LANES-1:0]        r_s1_data;
    logic [1:0]                 r_s1_mode;
    logic [ADDR_W-1:0]          r_s1_base;

    logic                       r_s2_vld;
    logic [ADDR_W*LANES-1:0]    r_s2_addr;
    logic [COEF_W*LANES-1:0]    r_s2_din;

    logic                       w_ready;
    logic                       w_accept;
    logic [ADDR_W*LANES-1:0]    w_addr;
    logic [COEF_W*LANES-1:0]    w_din;

    assign w_ready        = (r_state == S_LOAD) & i_read_working & ~i_module_start;
    assign w_accept       = s_rm.Rm_tvalid & w_ready;
    assign s_rm.Rm_tready = w_ready;

`ifdef COEF_RANGE_CHECK_EN
    logic [LANES-1:0]           w_lane_err;
    logic                       r_rerr;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [31:0] w_x;
        logic [32:0] w_sum;

        assign w_x = r_s1_data[32*g +: 32];

        always_comb begin
            if (r_s1_mode[1]) begin
                w_sum = {1'b0, w_x};
            end else if (!r_s1_mode[0]) begin
                w_sum = w_x[31] ? ({w_x[31], w_x} + Q33) : {1'b0, w_x};
            end else begin
                w_sum = ({1'b0, w_x} >= Q33) ? ({1'b0, w_x} - Q33) : {1'b0, w_x};
            end
        end

        assign w_din[COEF_W*g +: COEF_W]  = w_sum[COEF_W-1:0];
        assign w_addr[ADDR_W*g +: ADDR_W] = r_s1_base + ADDR_W'(g);

`ifdef COEF_RANGE_CHECK_EN
        // x < -Q leaves a negative 33-bit sum and x >= 2Q leaves x-Q >= Q,
        // so one unsigned compare of the corrected value covers every case.
        assign w_lane_err[g] = (w_sum >= Q33);
`else
        logic w_unused;
        assign w_unused = ^w_sum[32:COEF_W];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_drain <= 1'b0;
            r_base  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_module_start) begin
            r_state <= S_LOAD;
            r_drain <= 1'b0;
            r_base  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_base <= r_base + STEP;
                        if (r_base == LAST_BASE) begin
                            r_state <= S_DRAIN;
                            r_drain <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_IDLE, S_DONE: r_state <= S_IDLE;
                default:        r_state <= S_IDLE;
            endcase
        end
    end

    // Start flushes both stages so no stale beat reaches the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
            r_s1_mode <= '0;
            r_s1_base <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_din  <= '0;
        end else begin
            r_s1_vld <= w_accept;
            r_s2_vld <= r_s1_vld & ~i_module_start;
            if (w_accept) begin
                r_s1_data <= s_rm.Rm_tdata;
                r_s1_mode <= i_mode;
                r_s1_base <= r_base;
            end
            if (r_s1_vld) begin
                r_s2_addr <= w_addr;
                r_s2_din  <= w_din;
            end
        end
    end

`ifdef COEF_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rerr <= 1'b0;
        end else if (i_module_start) begin
            r_rerr <= 1'b0;
        end else if (r_s1_vld && (|w_lane_err)) begin
            r_rerr <= 1'b1;
        end
    end

    assign o_range_err = r_rerr;
`else
    assign o_range_err = 1'b0;
`endif

    assign o_coef_we     = {LANES{r_s2_vld}};
    assign o_coef_addr   = r_s2_addr;
    assign o_coef_din    = r_s2_din;
    assign o_busy        = r_busy;
    assign o_module_done = r_done;

endmodule

// File: tb/tb_coef_stream_loader.sv
// Randomised bench for coef_stream_loader against a queue-based reference model.
// Covers frames in all modes, stalls, restarts, mid-frame reset and range errors.
module tb_coef_stream_loader;

    localparam int LANES  = 2;
    localparam int DEPTH  = 256;
    localparam int COEF_W = 23;
    localparam int Q      = 8380417;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NBEATS = DEPTH / LANES;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    rw = 1'b0;
    logic [1:0]              mode = 2'b00;
    logic [LANES-1:0]        we;
    logic [ADDR_W*LANES-1:0] addr;
    logic [COEF_W*LANES-1:0] din;
    logic                    busy;
    logic                    done;
    logic                    rerr;

    coef_stream_loader_if #(.LANES(LANES)) rm();

    coef_stream_loader #(
        .LANES (LANES),
        .DEPTH (DEPTH),
        .COEF_W(COEF_W),
        .Q     (Q),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_module_start(start),
        .i_read_working(rw),
        .i_mode        (mode),
        .s_rm          (rm),
        .o_coef_we     (we),
        .o_coef_addr   (addr),
        .o_coef_din    (din),
        .o_busy        (busy),
        .o_module_done (done),
        .o_range_err   (rerr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the mode rules, in 64-bit integers.
    function automatic longint corr(input logic [31:0] x, input logic [1:0] m);
        longint v;
        if (m == 2'b00) begin
            v = longint'($signed(x));
            if (v < 0) v = v + Q;
        end else if (m == 2'b01) begin
            v = longint'(x);
            if (v >= Q) v = v - Q;
        end else begin
            v = longint'(x);
        end
        return v;
    endfunction

    function automatic bit ref_err(input logic [31:0] x, input logic [1:0] m);
        if (m == 2'b00 && longint'($signed(x)) < -longint'(Q)) return 1'b1;
        if (m == 2'b01 && longint'(x) >= 2 * longint'(Q)) return 1'b1;
        return corr(x, m) >= longint'(Q);
    endfunction

    function automatic logic [31:0] gen_word(input logic [1:0] m);
        if (m == 2'b00) begin
            if ($urandom_range(0, 1) == 1) return 32'($urandom_range(0, Q - 1));
            return 32'(-int'($urandom_range(1, Q)));
        end
        if (m == 2'b01) return 32'($urandom_range(0, 2 * Q - 1));
        return $urandom();
    endfunction

    typedef struct {
        int                  at;
        int                  base;
        logic [32*LANES-1:0] data;
        logic [1:0]          m;
    } beat_t;

    beat_t sb[$];
    int    cyc = 0;
    int    done_at = -1;
    int    beats = 0;
    bit    loading = 1'b0;
    bit    busy_m = 1'b0;
    bit    rerr_m = 1'b0;

    always @(negedge clk) begin : mon
        beat_t       b;
        beat_t       nb;
        logic [31:0] w;
        longint      cv;
        if (!rst_n) begin
            sb.delete();
            loading = 1'b0;
            busy_m  = 1'b0;
            rerr_m  = 1'b0;
            done_at = -1;
            beats   = 0;
        end else begin
            cyc++;
            if (cyc == done_at) busy_m = 1'b0;
            chk("done", done, cyc == done_at);
            chk("busy", busy, busy_m);
            chk("tready", rm.Rm_tready, loading && rw && !start);
            if (sb.size() > 0 && sb[0].at == cyc) begin
                b = sb.pop_front();
                chk("we", we, {LANES{1'b1}});
                for (int l = 0; l < LANES; l++) begin
                    w  = b.data[32*l +: 32];
                    cv = corr(w, b.m);
                    chk("addr", addr[ADDR_W*l +: ADDR_W], 64'(b.base + l));
                    chk("din", din[COEF_W*l +: COEF_W], 64'(cv[COEF_W-1:0]));
`ifdef COEF_RANGE_CHECK_EN
                    if (ref_err(w, b.m)) rerr_m = 1'b1;
`endif
                end
            end else begin
                chk("we_idle", we, '0);
            end
            chk("range_err", rerr, rerr_m);
            if (start) begin
                sb.delete();
                loading = 1'b1;
                busy_m  = 1'b1;
                rerr_m  = 1'b0;
                done_at = -1;
                beats   = 0;
            end else if (rm.Rm_tvalid && loading && rw) begin
                nb.at   = cyc + 2;
                nb.base = beats * LANES;
                nb.data = rm.Rm_tdata;
                nb.m    = mode;
                sb.push_back(nb);
                beats++;
                if (beats == NBEATS) begin
                    loading = 1'b0;
                    done_at = cyc + 3;
                end
            end
        end
    end

    task automatic idle(input int n, input bit v);
        rm.Rm_tvalid = v;
        rw = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rm.Rm_tvalid = 1'b0;
    endtask

    task automatic frame(input logic [1:0] m, input logic [31:0] w0,
                         input logic [31:0] w1, input int stop_at, input bit stall);
        int                  got = 0;
        int                  guard = 0;
        logic [32*LANES-1:0] cur;
        cur = {w1, w0};
        @(posedge clk);
        #1;
        start        = 1'b1;
        mode         = m;
        rw           = 1'b1;
        rm.Rm_tvalid = 1'b1;
        rm.Rm_tdata  = cur;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (got < stop_at && guard < 2000) begin
            rw           = stall ? (guard % 2 == 0) : 1'b1;
            rm.Rm_tvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rm.Rm_tdata  = cur;
            @(negedge clk);
            if (rm.Rm_tvalid && rm.Rm_tready) begin
                got++;
                for (int l = 0; l < LANES; l++) cur[32*l +: 32] = gen_word(m);
            end
            @(posedge clk);
            #1;
            guard++;
        end
        rm.Rm_tvalid = 1'b0;
        chk("frame_beats", got, stop_at);
    endtask

    initial begin
        rm.Rm_tvalid = 1'b0;
        rm.Rm_tdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", we, '0);
        chk("rst_addr", addr, '0);
        chk("rst_din", din, '0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tready", rm.Rm_tready, 0);
        chk("rst_rerr", rerr, 0);
        rst_n = 1'b1;
        idle(2, 1'b0);

        frame(2'b00, 32'hFFFF_FFFF, 32'h0000_0005, NBEATS, 1'b0);
        idle(6, 1'b1);
        frame(2'b01, 32'd8380418, 32'd8380416, NBEATS, 1'b1);
        idle(6, 1'b0);
        frame(2'b10, 32'h007F_FFFF, 32'h1234_5678, 40, 1'b0);
        frame(2'b10, 32'h007F_FFFF, 32'hFFFF_FFFF, NBEATS, 1'b0);
        idle(6, 1'b1);
        frame(2'b00, 32'h0000_0000, 32'h8000_0001 + 32'(Q), NBEATS, 1'b0);
        frame(2'b01, 32'd0, 32'(Q - 1), NBEATS, 1'b1);
        idle(6, 1'b0);

        frame(2'b01, 32'd7, 32'd9, 60, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", we, '0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_tready", rm.Rm_tready, 0);
        chk("midrst_addr", addr, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2, 1'b0);

        frame(2'b00, 32'hFF80_0000, 32'h0000_0001, NBEATS, 1'b0);
        idle(8, 1'b0);
`ifdef COEF_RANGE_CHECK_EN
        chk("rerr_hold", rerr, 1);
`else
        chk("rerr_hold", rerr, 0);
`endif
        frame(2'b00, 32'd5, 32'd6, NBEATS, 1'b1);
        idle(8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
